ibf_peel_decoder: RTL and testbench

//  Decodes a difference IBF (IBF1 minus IBF2) by iterative peeling. It scans for pure cells,

---
 rtl/ibf_pkg.sv | 61 ++++++
 rtl/ibf_cell_hash.sv | 15 +
 rtl/ibf_peel_decoder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ibf_peel_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibf_pkg.sv
// Shared constants, cell layout, FSM state encoding and the key hash used by
// both the IBF programming path and the peeling decoder.
// Hash: CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first over the key, no
// final XOR). h1 = crc[31:27], h2 = crc[26:22], sig = crc[26:19] (the SIG_W
// bits directly under the top of the CRC), h3 = crc[IDX_W-1:0].
package ibf_pkg;

    localparam int KEY_W    = 32;
    localparam int SIG_W    = 8;
    localparam int CNT_W    = 8;
    localparam int IDX_W    = 5;
    localparam int CELL_W   = KEY_W + SIG_W + CNT_W;
    localparam int IBF_SIZE = 2 ** IDX_W;

    // Cell field offsets: {key, sig, count}, key in the MSBs.
    localparam int CNT_LSB  = 0;
    localparam int SIG_LSB  = CNT_W;
    localparam int KEY_LSB  = CNT_W + SIG_W;

    localparam logic [31:0]      CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0] CNT_POS1 = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_NEG1 = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_EMIT   = 3'd3,
        ST_REM1   = 3'd4,
        ST_REM2   = 3'd5,
        ST_REM3   = 3'd6,
        ST_FINISH = 3'd7
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] h1;
        logic [IDX_W-1:0] h2;
        logic [IDX_W-1:0] h3;
        logic [SIG_W-1:0] sig;
    } hash_t;

    function automatic hash_t ibf_hash(input logic [KEY_W-1:0] key);
        logic [31:0] crc;
        logic        fb;
        hash_t       h;
        crc = CRC_INIT;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            fb  = crc[31] ^ key[i];
            crc = {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
        end
        h.h1  = crc[31 -: IDX_W];
        h.h2  = crc[31 - IDX_W -: IDX_W];
        h.sig = crc[31 - IDX_W -: SIG_W];
        h.h3  = crc[IDX_W-1:0];
        return h;
    endfunction

endpackage

// File: rtl/ibf_cell_hash.sv
// Combinational wrapper around ibf_hash; evaluates the key of the cell the
// decoder is currently looking at.
module ibf_cell_hash
    import ibf_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    output hash_t            hash
);

    // Hash the presented key.
    always_comb begin
        hash = ibf_hash(key);
    end

endmodule

// File: rtl/ibf_peel_decoder.sv
// Difference-IBF peeling decoder. The host loads cells while idle, pulses
// start, drains recovered keys over a valid/ready port and reads the verdict.
// Optional feature macro: IBF_PEEL_STATS_EN adds peel_cnt / pass_cnt outputs.
module ibf_peel_decoder
    import ibf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [CELL_W-1:0] load_cell,
    input  logic              start,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_side,
    output logic              busy,
    output logic              done,
    output logic              success
`ifdef IBF_PEEL_STATS_EN
    ,
    output logic [IDX_W:0]    peel_cnt,
    output logic [7:0]        pass_cnt
`endif
);

    state_t             state_r, state_s;
    logic [CELL_W-1:0]  cells_r [IBF_SIZE];
    logic [IDX_W-1:0]   ptr_r;
    logic               progress_r, nonzero_r;
    logic [KEY_W-1:0]   key_r;
    logic               side_r;
    logic [SIG_W-1:0]   sig_r;
    logic [IDX_W-1:0]   h1_r, h2_r, h3_r;
    logic               key_valid_r, busy_r, done_r, success_r;

    logic [IDX_W-1:0]   rd_addr_s;
    logic [CELL_W-1:0]  rd_cell_s;
    logic [KEY_W-1:0]   rd_key_s;
    logic [SIG_W-1:0]   rd_sig_s;
    logic [CNT_W-1:0]   rd_cnt_s;
    hash_t              hash_s;
    logic               cell_nz_s, pure_s, last_s, handshake_s;
    logic               wr_en_s;
    logic [IDX_W-1:0]   wr_addr_s;
    logic [CELL_W-1:0]  wr_data_s;

    assign rd_cell_s   = cells_r[rd_addr_s];
    assign rd_key_s    = rd_cell_s[KEY_LSB +: KEY_W];
    assign rd_sig_s    = rd_cell_s[SIG_LSB +: SIG_W];
    assign rd_cnt_s    = rd_cell_s[CNT_LSB +: CNT_W];
    assign cell_nz_s   = |rd_cell_s;
    assign last_s      = (ptr_r == IDX_LAST);
    assign handshake_s = key_valid_r & key_ready;

    ibf_cell_hash u_hash (
        .key  (rd_key_s),
        .hash (hash_s)
    );

    // A cell is pure when |count| is one, its signature matches its key and
    // the scan index is one of that key's own cells.
    always_comb begin
        pure_s = ((rd_cnt_s == CNT_POS1) || (rd_cnt_s == CNT_NEG1))
               && (rd_sig_s == hash_s.sig)
               && ((ptr_r == hash_s.h1) || (ptr_r == hash_s.h2) || (ptr_r == hash_s.h3));
    end

    // Single read port: scan pointer, or the hashed cell being removed.
    always_comb begin
        case (state_r)
            ST_REM1: rd_addr_s = h1_r;
            ST_REM2: rd_addr_s = h2_r;
            ST_REM3: rd_addr_s = h3_r;
            default: rd_addr_s = ptr_r;
        endcase
    end

    // Single write port: host loads while idle, read-modify-write during removal.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = rd_addr_s;
        wr_data_s = rd_cell_s;
        case (state_r)
            ST_IDLE: begin
                wr_en_s   = load_valid;
                wr_addr_s = load_addr;
                wr_data_s = load_cell;
            end
            ST_REM1, ST_REM2, ST_REM3: begin
                wr_en_s   = 1'b1;
                wr_addr_s = rd_addr_s;
                wr_data_s = {rd_key_s ^ key_r,
                             rd_sig_s ^ sig_r,
                             side_r ? (rd_cnt_s + CNT_POS1) : (rd_cnt_s - CNT_POS1)};
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Next-state logic of the peeling sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_SCAN;
                else       state_s = ST_IDLE;
            end
            ST_SCAN: begin
                if (pure_s)                    state_s = ST_CHECK;
                else if (last_s && !progress_r) state_s = ST_FINISH;
                else                           state_s = ST_SCAN;
            end
            ST_CHECK: state_s = ST_EMIT;
            ST_EMIT: begin
                if (handshake_s) state_s = ST_REM1;
                else             state_s = ST_EMIT;
            end
            ST_REM1:   state_s = ST_REM2;
            ST_REM2:   state_s = ST_REM3;
            ST_REM3:   state_s = ST_SCAN;
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Cell array storage; cleared on reset so a stale decode cannot leak.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IBF_SIZE; i++) cells_r[i] <= {CELL_W{1'b0}};
        end else if (wr_en_s) begin
            cells_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Scan pointer, pass flags, latched key/hash and registered host outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r       <= {IDX_W{1'b0}};
            progress_r  <= 1'b0;
            nonzero_r   <= 1'b0;
            key_r       <= {KEY_W{1'b0}};
            side_r      <= 1'b0;
            sig_r       <= {SIG_W{1'b0}};
            h1_r        <= {IDX_W{1'b0}};
            h2_r        <= {IDX_W{1'b0}};
            h3_r        <= {IDX_W{1'b0}};
            key_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            success_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r     <= 1'b1;
                        success_r  <= 1'b0;
                        ptr_r      <= {IDX_W{1'b0}};
                        progress_r <= 1'b0;
                        nonzero_r  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (pure_s) begin
                        key_r     <= rd_key_s;
                        side_r    <= (rd_cnt_s == CNT_NEG1);
                        nonzero_r <= nonzero_r | cell_nz_s;
                    end else if (last_s && progress_r) begin
                        ptr_r      <= {IDX_W{1'b0}};
                        progress_r <= 1'b0;
                        nonzero_r  <= 1'b0;
                    end else if (last_s) begin
                        nonzero_r <= nonzero_r | cell_nz_s;
                    end else begin
                        ptr_r     <= ptr_r + IDX_ONE;
                        nonzero_r <= nonzero_r | cell_nz_s;
                    end
                end
                ST_CHECK: begin
                    h1_r        <= hash_s.h1;
                    h2_r        <= hash_s.h2;
                    h3_r        <= hash_s.h3;
                    sig_r       <= hash_s.sig;
                    key_valid_r <= 1'b1;
                end
                ST_EMIT: begin
                    if (handshake_s) key_valid_r <= 1'b0;
                end
                ST_REM3: begin
                    // The removal counts as progress; wrapping ends this pass
                    // and therefore starts a fresh one.
                    if (last_s) begin
                        ptr_r      <= {IDX_W{1'b0}};
                        progress_r <= 1'b0;
                        nonzero_r  <= 1'b0;
                    end else begin
                        ptr_r      <= ptr_r + IDX_ONE;
                        progress_r <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    success_r <= ~nonzero_r;
                end
                default: begin
                    key_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef IBF_PEEL_STATS_EN
    logic [IDX_W:0] peel_cnt_r;
    logic [7:0]     pass_cnt_r;
    logic           pass_end_s;

    // A pass ends when the scan leaves the last cell, either plainly or after a peel.
    always_comb begin
        pass_end_s = ((state_r == ST_SCAN) && !pure_s && last_s)
                   || ((state_r == ST_REM3) && last_s);
    end

    // Decode statistics: keys emitted and passes completed (saturating).
    always_ff @(posedge clk) begin
        if (reset) begin
            peel_cnt_r <= {(IDX_W+1){1'b0}};
            pass_cnt_r <= 8'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            peel_cnt_r <= {(IDX_W+1){1'b0}};
            pass_cnt_r <= 8'd0;
        end else begin
            if ((state_r == ST_EMIT) && handshake_s) peel_cnt_r <= peel_cnt_r + {{IDX_W{1'b0}}, 1'b1};
            else                                    peel_cnt_r <= peel_cnt_r;
            if (pass_end_s && (pass_cnt_r != 8'hFF)) pass_cnt_r <= pass_cnt_r + 8'd1;
            else                                     pass_cnt_r <= pass_cnt_r;
        end
    end

    assign peel_cnt = peel_cnt_r;
    assign pass_cnt = pass_cnt_r;
`endif

    assign key_valid = key_valid_r;
    assign key_out   = key_r;
    assign key_side  = side_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign success   = success_r;

endmodule

// File: tb/tb_ibf_peel_decoder.sv
// Self-checking bench for ibf_peel_decoder: table of single-key scenarios,
// plus hand-written two-key, backpressure and mid-operation reset sequences.
module tb_ibf_peel_decoder;

    localparam int KW = 32;
    localparam int IW = 5;
    localparam int CW = 48;
    localparam int NC = 32;

    logic          clk, reset, load_valid, start, key_ready;
    logic [IW-1:0] load_addr;
    logic [CW-1:0] load_cell;
    logic          key_valid, key_side, busy, done, success;
    logic [KW-1:0] key_out;
`ifdef IBF_PEEL_STATS_EN
    logic [IW:0]   peel_cnt;
    logic [7:0]    pass_cnt;
`endif

    typedef struct packed {
        logic [31:0] key;
        logic        side;
    } exp_t;

    typedef struct {
        logic [31:0] key;
        int          cnt_a;
        int          cnt_b;
        int          exp_n;
        bit          exp_side;
        bit          exp_succ;
        int          exp_lat;
    } vec_t;

    exp_t          sb_q[$];
    logic [CW-1:0] m_cells [NC];
    vec_t          vecs [7];
    int            cmp_cnt = 0;
    int            err_cnt = 0;

    ibf_peel_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_cell  (load_cell),
        .start      (start),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .key_side   (key_side),
        .busy       (busy),
        .done       (done),
        .success    (success)
`ifdef IBF_PEEL_STATS_EN
        ,
        .peel_cnt   (peel_cnt),
        .pass_cnt   (pass_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference CRC: initial value folded into the message word, then 32 shifts.
    function automatic logic [31:0] ref_crc(input logic [31:0] k);
        logic [31:0] c;
        c = 32'hFFFF_FFFF ^ k;
        for (int i = 0; i < 32; i++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        return c;
    endfunction

    function automatic logic [4:0] ref_idx(input logic [31:0] k, input int which);
        logic [31:0] c;
        c = ref_crc(k);
        if (which == 0)      return c[31:27];
        else if (which == 1) return c[26:22];
        else                 return c[4:0];
    endfunction

    function automatic logic [7:0] ref_sig(input logic [31:0] k);
        logic [31:0] c;
        c = ref_crc(k);
        return c[26:19];
    endfunction

    function automatic bit distinct(input logic [31:0] k);
        return (ref_idx(k, 0) != ref_idx(k, 1)) && (ref_idx(k, 0) != ref_idx(k, 2))
            && (ref_idx(k, 1) != ref_idx(k, 2));
    endfunction

    function automatic logic [4:0] min_idx(input logic [31:0] k);
        logic [4:0] m;
        m = ref_idx(k, 0);
        if (ref_idx(k, 1) < m) m = ref_idx(k, 1);
        if (ref_idx(k, 2) < m) m = ref_idx(k, 2);
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_cells[i] = '0;
    endtask

    task automatic model_insert(input logic [31:0] k, input int d);
        logic [4:0] ix;
        for (int j = 0; j < 3; j++) begin
            ix = ref_idx(k, j);
            m_cells[ix][47:16] = m_cells[ix][47:16] ^ k;
            m_cells[ix][15:8]  = m_cells[ix][15:8] ^ ref_sig(k);
            m_cells[ix][7:0]   = m_cells[ix][7:0] + 8'(d);
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_addr  = 5'(i);
            load_cell  = m_cells[i];
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Pulse start, drain keys against the scoreboard, check verdict and timing.
    task automatic run_decode(input string nm, input bit exp_succ, input int exp_lat);
        int   n;
        bit   seen;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4000) begin
            if (key_valid && key_ready) begin
                check({nm, "_key_expected"}, 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check({nm, "_key_out"}, 64'(key_out), 64'(e.key));
                    check({nm, "_key_side"}, 64'(key_side), 64'(e.side));
                end
            end
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({nm, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            if (exp_lat >= 0) check({nm, "_latency"}, 64'(n), 64'(exp_lat));
            check({nm, "_success"}, 64'(success), 64'(exp_succ));
            check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
            @(negedge clk);
            check({nm, "_done_pulse"}, 64'(done), 64'd0);
            check({nm, "_success_held"}, 64'(success), 64'(exp_succ));
        end
        check({nm, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        logic [31:0] ka, kb;
        logic [31:0] k4;
        int          w;
        bit          got;

        vecs[0] = '{32'h0000_0000,  0,  0, 0, 1'b0, 1'b1, 33};
        vecs[1] = '{32'h1234_5678,  1,  0, 1, 1'b0, 1'b1, -1};
        vecs[2] = '{32'hDEAD_BEEF, -1,  0, 1, 1'b1, 1'b1, -1};
        vecs[3] = '{32'h0000_0000,  1,  0, 1, 1'b0, 1'b1, -1};
        vecs[4] = '{32'h1234_5678,  1,  1, 0, 1'b0, 1'b0, 33};
        vecs[5] = '{32'hCAFE_F00D,  1, -1, 0, 1'b0, 1'b1, 33};
        vecs[6] = '{32'hDEAD_BEEF, -1, -1, 0, 1'b0, 1'b0, 33};

        reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_cell = '0;
        start = 1'b0; key_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_key_valid", 64'(key_valid), 64'd0);
        check("reset_busy",      64'(busy),      64'd0);
        check("reset_done",      64'(done),      64'd0);
        check("reset_success",   64'(success),   64'd0);
        check("reset_key_out",   64'(key_out),   64'd0);

        // Table-driven single-key scenarios.
        for (int v = 0; v < 7; v++) begin
            model_clear();
            if (vecs[v].cnt_a != 0) model_insert(vecs[v].key, vecs[v].cnt_a);
            if (vecs[v].cnt_b != 0) model_insert(vecs[v].key, vecs[v].cnt_b);
            for (int k = 0; k < vecs[v].exp_n; k++) sb_q.push_back('{vecs[v].key, vecs[v].exp_side});
            load_all();
            key_ready = 1'b1;
            run_decode($sformatf("vec%0d", v), vecs[v].exp_succ, vecs[v].exp_lat);
        end

        // Two keys from opposite sides on disjoint cells, emitted in scan order.
        ka = 32'h1234_5678;
        while (!distinct(ka)) ka = ka + 32'd1;
        kb = 32'hA000_0000;
        for (int t = 0; t < 20000; t++) begin
            if (distinct(kb)
                && (ref_idx(kb, 0) != ref_idx(ka, 0)) && (ref_idx(kb, 0) != ref_idx(ka, 1)) && (ref_idx(kb, 0) != ref_idx(ka, 2))
                && (ref_idx(kb, 1) != ref_idx(ka, 0)) && (ref_idx(kb, 1) != ref_idx(ka, 1)) && (ref_idx(kb, 1) != ref_idx(ka, 2))
                && (ref_idx(kb, 2) != ref_idx(ka, 0)) && (ref_idx(kb, 2) != ref_idx(ka, 1)) && (ref_idx(kb, 2) != ref_idx(ka, 2)))
                break;
            kb = kb + 32'd1;
        end
        model_clear();
        model_insert(ka, 1);
        model_insert(kb, -1);
        if (min_idx(ka) < min_idx(kb)) begin
            sb_q.push_back('{ka, 1'b0});
            sb_q.push_back('{kb, 1'b1});
        end else begin
            sb_q.push_back('{kb, 1'b1});
            sb_q.push_back('{ka, 1'b0});
        end
        load_all();
        run_decode("two_sides", 1'b1, -1);

        // Backpressure: key held steady for 10 stalled cycles, one transfer.
        k4 = 32'h1234_5678;
        model_clear();
        model_insert(k4, 1);
        load_all();
        key_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!key_valid && w < 500) begin @(negedge clk); w++; end
        check("bp_valid_seen", 64'(key_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold_valid_%0d", i), 64'(key_valid), 64'd1);
            check($sformatf("bp_hold_key_%0d", i), 64'(key_out), 64'(k4));
            check($sformatf("bp_hold_side_%0d", i), 64'(key_side), 64'd0);
            @(negedge clk);
        end
        key_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 64'(key_valid), 64'd0);
        w = 0; got = 1'b0;
        while (!done && w < 500) begin
            if (key_valid) got = 1'b1;
            @(negedge clk); w++;
        end
        check("bp_done_seen", 64'(done), 64'd1);
        check("bp_extra_key", 64'(got), 64'd0);
        check("bp_success", 64'(success), 64'd1);

        // Reset while a key is waiting in EMIT, then an empty decode.
        model_clear();
        model_insert(k4, 1);
        load_all();
        key_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!key_valid && w < 500) begin @(negedge clk); w++; end
        check("rst_valid_seen", 64'(key_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_key_valid", 64'(key_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        key_ready = 1'b1;
        run_decode("after_reset", 1'b1, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
